load_store_unit: RTL

// Sits between the datapath and the word-addressed memory_block. Accepts byte-addressed

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_if.sv | 25 ++
 rtl/lsu_lane_align.sv | 47 ++++
 rtl/load_store_unit.sv | 135 +++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// alignment rule used to reject requests before they reach memory.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP
  } state_e;

  // Halves need an even offset, words a zero offset; the 11 encoding is never legal.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = offset[0];
      SZ_WORD: is_misaligned = (offset != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response channel between the datapath (master) and the load/store unit (slave).
interface lsu_if #(
  parameter int ADDR_W = 18
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts and extends a load lane from a memory word,
// and merges store lanes over the old word for read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_e       i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_word,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic [31:0] w_shifted;
  logic [31:0] w_store_lanes;
  logic [3:0]  w_byte_en;

  assign w_shifted     = i_word >> {i_offset, 3'b000};
  assign w_store_lanes = i_wdata << {i_offset, 3'b000};

  always_comb begin
    o_load_data = i_word;
    case (i_size)
      SZ_BYTE: o_load_data = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: o_load_data = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: o_load_data = i_word;
    endcase
  end

  always_comb begin
    w_byte_en = 4'b1111;
    case (i_size)
      SZ_BYTE: w_byte_en = 4'b0001 << i_offset;
      SZ_HALF: w_byte_en = 4'b0011 << i_offset;
      default: w_byte_en = 4'b1111;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign o_merged[8*gi +: 8] = w_byte_en[gi] ? w_store_lanes[8*gi +: 8] : i_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed memory. Sub-word stores
// go through read-modify-write; misaligned requests are answered without memory access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              reset,
  lsu_if.slave              bus,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  state_e            r_state;
  size_e             r_size;
  logic              r_unsigned;
  logic [1:0]        r_offset;
  logic [31:0]       r_wdata;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [31:0]       r_resp_rdata;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_address;
  logic [31:0]       r_mem_write_data;

  size_e             w_req_size;
  logic [31:0]       w_load_data;
  logic [31:0]       w_merged;

  assign w_req_size = size_e'(bus.req_size);

  lsu_lane_align u_lane_align (
    .i_size      (r_size),
    .i_unsigned  (r_unsigned),
    .i_offset    (r_offset),
    .i_wdata     (r_wdata),
    .i_word      (mem_read_data),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  // Strobes are registered on the transition into each state so they hold for the whole cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_size           <= SZ_BYTE;
      r_unsigned       <= 1'b0;
      r_offset         <= 2'b00;
      r_wdata          <= '0;
      r_req_ready      <= 1'b1;
      r_resp_valid     <= 1'b0;
      r_resp_err       <= 1'b0;
      r_resp_rdata     <= '0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_address    <= '0;
      r_mem_write_data <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_req_ready  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (bus.req_valid) begin
            r_req_ready   <= 1'b0;
            r_size        <= w_req_size;
            r_unsigned    <= bus.req_unsigned;
            r_offset      <= bus.req_addr[1:0];
            r_wdata       <= bus.req_wdata;
            r_mem_address <= bus.req_addr[ADDR_W+1:2];
            if (is_misaligned(w_req_size, bus.req_addr[1:0])) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else if (!bus.req_write) begin
              r_state    <= ST_READ;
              r_mem_read <= 1'b1;
            end else if (w_req_size == SZ_WORD) begin
              r_state          <= ST_WRITE;
              r_mem_write      <= 1'b1;
              r_mem_write_data <= bus.req_wdata;
            end else begin
              r_state    <= ST_RMW_RD;
              r_mem_read <= 1'b1;
            end
          end
        end
        ST_READ: begin
          r_state      <= ST_RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= w_load_data;
        end
        ST_WRITE, ST_RMW_WR: begin
          r_state      <= ST_RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
        end
        ST_RMW_RD: begin
          r_state          <= ST_RMW_WR;
          r_mem_write      <= 1'b1;
          r_mem_write_data <= w_merged;
        end
        ST_RESP: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_err    = r_resp_err;
  assign bus.resp_rdata  = r_resp_rdata;
  assign mem_read        = r_mem_read;
  assign mem_write       = r_mem_write;
  assign mem_address     = r_mem_address;
  assign mem_write_data  = r_mem_write_data;

endmodule
